// File: rtl/monolit_fetch_pkg.sv
// monolit_fetch_pkg: shared types for the instruction fetch stage
package monolit_fetch_pkg;
  typedef enum logic {FETCH, FLUSH} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous prefetch FIFO with flush taking priority over push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WORD_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WORD_WIDTH-1:0]   din,
  output logic [$clog2(DEPTH):0]  count,
  output logic [WORD_WIDTH-1:0]   head
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [CW-2:0] rd, wr;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  assign head = mem[rd];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: credit-limited instruction prefetch with redirect flush
module instr_fetch_queue
  import monolit_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  output logic                  inst_valid_o,
  output logic [WORD_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o,
  input  logic                  inst_ready_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);
  fetch_state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] fetch_pc, head_pc;
  logic [CW-1:0] count, outstanding, outstanding_nx;
  logic grant, resp, push, pop;
  // queued plus in-flight words never exceed capacity, so a push always has room
  assign mem_req_o = state == FETCH && !redirect_i && ({1'b0, count} + {1'b0, outstanding}) < CAP;
  assign mem_addr_o = fetch_pc;
  assign grant = mem_req_o && mem_gnt_i;
  assign resp = mem_rvalid_i && outstanding != '0;
  assign push = resp && state == FETCH && !redirect_i;
  assign inst_valid_o = count != '0 && !redirect_i;
  assign pop = inst_valid_o && inst_ready_i;
  assign inst_addr_o = head_pc;
  assign outstanding_nx = outstanding + CW'(grant) - CW'(resp);
  always_comb
    state_nx = (redirect_i || state == FLUSH) ? (outstanding_nx != '0 ? FLUSH : FETCH) : FETCH;
  always_ff @(posedge clk_i)
    state <= rst_i ? FETCH : state_nx;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_ADDR;
      head_pc <= RESET_ADDR;
      outstanding <= '0;
    end else begin
      outstanding <= outstanding_nx;
      fetch_pc <= redirect_i ? redirect_addr_i : fetch_pc + ADDR_WIDTH'(grant);
      head_pc <= redirect_i ? redirect_addr_i : head_pc + ADDR_WIDTH'(pop);
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .WORD_WIDTH(WORD_WIDTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(push),
    .pop(pop),
    .flush(redirect_i),
    .din(mem_rdata_i),
    .count(count),
    .head(inst_o)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: random fetch traffic checked against a queue-based reference model
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [7:0] RA = 8'hFE;
  logic clk = 0;
  logic rst_i, redirect_i, mem_gnt_i, mem_rvalid_i, inst_ready_i, mem_req_o, inst_valid_o;
  logic [7:0] redirect_addr_i, mem_addr_o, inst_addr_o;
  logic [31:0] mem_rdata_i, inst_o;
  typedef struct {logic [7:0] a; logic [31:0] d; bit live;} ent_t;
  ent_t infl[$];
  ent_t q[$];
  ent_t e;
  logic [7:0] fpc;
  bit exp_req, exp_valid, dead, after_rst;
  int vectors = 0, miscompares = 0;
  int gnt_p, rdy_p;
  always #5 clk = ~clk;
  instr_fetch_queue #(.ADDR_WIDTH(8), .WORD_WIDTH(32), .DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk_i(clk), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_ready_i(inst_ready_i)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial begin
    rst_i = 1; redirect_i = 0; redirect_addr_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0; inst_ready_i = 0;
    @(posedge clk);
    infl.delete(); q.delete(); fpc = RA; after_rst = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      gnt_p = (cyc / 500) % 4 == 1 ? 30 : 90;
      rdy_p = (cyc / 500) % 4 == 2 ? 5 : ((cyc / 500) % 4 == 3 ? 50 : 90);
      rst_i = cyc > 20 && $urandom_range(199) == 0;
      redirect_i = cyc > 20 && $urandom_range(99) < 4;
      redirect_addr_i = 8'($urandom);
      mem_gnt_i = $urandom_range(99) < gnt_p;
      inst_ready_i = $urandom_range(99) < rdy_p;
      mem_rvalid_i = (infl.size() > 0 && $urandom_range(99) < 70) || (after_rst && $urandom_range(1) == 1);
      mem_rdata_i = $urandom;
      #1;
      dead = 0;
      foreach (infl[i]) if (!infl[i].live) dead = 1;
      exp_req = !dead && !redirect_i && (q.size() + infl.size()) < DEPTH;
      exp_valid = q.size() > 0 && !redirect_i;
      check("mem_req", 32'(mem_req_o), 32'(exp_req));
      check("mem_addr", 32'(mem_addr_o), 32'(fpc));
      check("inst_valid", 32'(inst_valid_o), 32'(exp_valid));
      if (exp_valid) begin
        check("inst_data", inst_o, q[0].d);
        check("inst_addr", 32'(inst_addr_o), 32'(q[0].a));
      end
      @(posedge clk);
      if (rst_i) begin
        infl.delete(); q.delete(); fpc = RA; after_rst = 1;
      end else begin
        after_rst = 0;
        if (exp_valid && inst_ready_i) void'(q.pop_front());
        if (mem_rvalid_i && infl.size() > 0) begin
          e = infl.pop_front();
          if (e.live && !redirect_i) begin
            e.d = mem_rdata_i;
            q.push_back(e);
          end
        end
        if (redirect_i) begin
          foreach (infl[i]) infl[i].live = 0;
          q.delete();
          fpc = redirect_addr_i;
        end else if (exp_req && mem_gnt_i) begin
          infl.push_back('{a: fpc, d: 32'h0, live: 1'b1});
          fpc = fpc + 8'd1;
        end
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
